mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter (instruction fetch + data) in front of a
// shared, multi-cycle memory. One memory transaction is in flight at a time.
//
// Ports:
//   clk, rst                      clock, async active-low reset
//   i_req/i_addr/i_flush          fetch request, byte address, redirect flush
//   i_done/i_rdata/i_busy         fetch completion pulse, read data, pending
//   d_req/d_wr/d_addr/d_wdata     data request, write select, address, data
//   d_done/d_rdata/d_busy         data completion pulse, read data, pending
//   mem_rd/mem_wr/mem_addr/...    one-cycle command to memory, held addr/data
//   mem_done/mem_rdata/mem_err    memory completion, read data, error
//   err                           sticky memory error flag
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        i_flush,
   output logic        i_done,
   output logic [15:0] i_rdata,
   output logic        i_busy,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        d_busy,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_done,
   input  logic [15:0] mem_rdata,
   input  logic        mem_err,
   output logic        err
);

   localparam int CLOG = $clog2(STARVE_MAX + 1);
   localparam int CW   = (CLOG > 3) ? CLOG : 3;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   state_e        state_q;
   owner_e        owner_q;
   logic [15:0]   addr_q;
   logic [15:0]   wdata_q;
   logic          wr_q;
   logic          flushed_q;
   logic          err_q;
   logic          mem_rd_q;
   logic          mem_wr_q;
   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;

   logic starve_max;
   logic grant_i;
   logic grant_d;
   logic in_wait;

   // Data normally wins; the fetch port is forced through once it has
   // watched STARVE_MAX consecutive data grants go by.
   assign starve_max = (starve_q == CW'(STARVE_MAX));
   assign grant_i    = (state_q == S_IDLE) & i_req & (~d_req | starve_max);
   assign grant_d    = (state_q == S_IDLE) & d_req & ~grant_i;

   always_comb begin
      starve_d = starve_q;
      if (!i_req || grant_i)
         starve_d = '0;
      else if (grant_d && !starve_max)
         starve_d = starve_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         owner_q   <= OWN_I;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         flushed_q <= 1'b0;
         err_q     <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         starve_q  <= '0;
      end else begin
         starve_q <= starve_d;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         if (mem_err && state_q == S_WAIT)
            err_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               flushed_q <= 1'b0;
               // Command strobes are registered here so they are high for
               // exactly the ISSUE cycle.
               if (grant_i) begin
                  owner_q  <= OWN_I;
                  addr_q   <= i_addr;
                  wdata_q  <= '0;
                  wr_q     <= 1'b0;
                  mem_rd_q <= 1'b1;
                  state_q  <= S_ISSUE;
               end else if (grant_d) begin
                  owner_q  <= OWN_D;
                  addr_q   <= d_addr;
                  wdata_q  <= d_wdata;
                  wr_q     <= d_wr;
                  mem_rd_q <= ~d_wr;
                  mem_wr_q <= d_wr;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (i_flush && owner_q == OWN_I)
                  flushed_q <= 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (i_flush && owner_q == OWN_I)
                  flushed_q <= 1'b1;
               if (mem_done) begin
                  flushed_q <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_wait = (state_q == S_WAIT);

   // A flush arriving in the completion cycle itself still kills the pulse.
   assign i_done  = mem_done & in_wait & (owner_q == OWN_I) & ~flushed_q & ~i_flush;
   assign d_done  = mem_done & in_wait & (owner_q == OWN_D);
   assign i_rdata = i_done ? mem_rdata : '0;
   assign d_rdata = (d_done & ~wr_q) ? mem_rdata : '0;
   assign i_busy  = i_req & ~i_done;
   assign d_busy  = d_req & ~d_done;

   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// transactions scored against a transaction-level arbitration model.
module tb_mem_arbiter;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic        i_flush = 1'b0;
   logic        i_done;
   logic [15:0] i_rdata;
   logic        i_busy;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_done;
   logic [15:0] d_rdata;
   logic        d_busy;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_done = 1'b0;
   logic [15:0] mem_rdata = '0;
   logic        mem_err = 1'b0;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_done(i_done), .i_rdata(i_rdata), .i_busy(i_busy),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_busy(d_busy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for the next memory command; n is the number of edges it took.
   task automatic wait_cmd(output logic rd, output logic wr, output logic [15:0] a,
                           output logic [15:0] wd, output int n);
      n = 0; rd = 0; wr = 0; a = '0; wd = '0;
      while (n < 20) begin
         step();
         i_flush = 1'b0;
         n++;
         #1;
         if (mem_rd | mem_wr) begin
            rd = mem_rd; wr = mem_wr; a = mem_addr; wd = mem_wdata;
            return;
         end
      end
   endtask

   // Play memory: complete after lat WAIT cycles, optional flush on WAIT
   // cycle flush_at. extra counts stray commands, stray done pulses and
   // unmasked read data outside the completion cycle.
   task automatic serve(input int lat, input int flush_at, input logic [15:0] rdv,
                        input logic er, output logic idn, output logic [15:0] ird,
                        output logic ddn, output logic [15:0] drd, output int extra);
      extra = 0; idn = 0; ird = '0; ddn = 0; drd = '0;
      mem_rdata = ~rdv;
      for (int k = 0; k <= lat; k++) begin
         step();
         i_flush = (k == flush_at);
         if (k == lat) begin
            mem_done = 1'b1; mem_rdata = rdv; mem_err = er;
         end
         #1;
         if (mem_rd | mem_wr) extra++;
         if (k == lat) begin
            idn = i_done; ird = i_rdata; ddn = d_done; drd = d_rdata;
         end else if (i_done | d_done | (|i_rdata) | (|d_rdata)) begin
            extra++;
         end
      end
      step();
      mem_done = 1'b0; mem_err = 1'b0; mem_rdata = '0; i_flush = 1'b0;
   endtask

   logic        c_rd, c_wr, o_idn, o_ddn;
   logic [15:0] c_a, c_wd, o_ird, o_drd;
   int          n, extra;

   // reference-model state
   bit          ipend, dpend, dwr, fw;
   logic [15:0] ia, da, dw, rdv;
   int          streak, lat, fat, quiet;

   initial begin
      // ---- reset state
      step(); step();
      #1;
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_dones", {i_done, d_done}, 0);
      chk("rst_rdata", {i_rdata, d_rdata}, 0);
      rst = 1'b1;

      // ---- single fetch, memory answers 4 cycles after mem_rd
      i_req = 1; i_addr = 16'h0010;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      chk("fetch_lat", n, 1);
      chk("fetch_cmd", {c_rd, c_wr}, 2'b10);
      chk("fetch_addr", c_a, 16'h0010);
      chk("fetch_busy", i_busy, 1);
      serve(3, -1, 16'hA5A5, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("fetch_done", {o_idn, o_ddn}, 2'b10);
      chk("fetch_rdata", o_ird, 16'hA5A5);
      chk("fetch_extra", extra, 0);
      #1;
      chk("fetch_done_once", i_done, 0);
      i_req = 0;

      // ---- simultaneous: data write first, fetch right after
      i_req = 1; i_addr = 16'h0100;
      d_req = 1; d_wr = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      chk("sim_cmd", {c_rd, c_wr}, 2'b01);
      chk("sim_addr", c_a, 16'h0200);
      chk("sim_wdata", c_wd, 16'h1234);
      serve(1, -1, 16'hBEEF, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("sim_wdone", {o_idn, o_ddn}, 2'b01);
      chk("sim_wrdata", o_drd, 0);
      d_req = 0;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      chk("sim_fetch_lat", n, 1);
      chk("sim_fetch_addr", {c_rd, c_wr, c_a}, {2'b10, 16'h0100});
      serve(0, -1, 16'h5555, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("sim_fetch_done", {o_idn, o_ird}, {1'b1, 16'h5555});
      i_req = 0;

      // ---- starvation: both held, fetch forced every SMAX+1 grants
      i_req = 1; i_addr = 16'h0300;
      d_req = 1; d_wr = 0; d_addr = 16'h0400;
      for (int t = 0; t < 2 * (SMAX + 1); t++) begin
         wait_cmd(c_rd, c_wr, c_a, c_wd, n);
         chk("starve_addr", {n[3:0], c_a}, {4'd1, ((t % (SMAX + 1)) == SMAX) ? 16'h0300 : 16'h0400});
         serve(0, -1, 16'(t), 0, o_idn, o_ird, o_ddn, o_drd, extra);
      end
      i_req = 0; d_req = 0;

      // ---- flush during WAIT, flush on the completion cycle, then normal
      i_req = 1; i_addr = 16'h0040;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      serve(3, 1, 16'h7777, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("flush_nodone", {o_idn, o_ird, extra[3:0]}, 0);
      i_addr = 16'h0080;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      chk("flush_next_addr", {n[3:0], c_a}, {4'd1, 16'h0080});
      serve(1, 1, 16'h6666, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("flush_same_cycle", o_idn, 0);
      i_addr = 16'h00C0;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      serve(2, -1, 16'h4321, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("flush_recover", {o_idn, o_ird}, {1'b1, 16'h4321});
      i_req = 0;

      // ---- mem_done outside WAIT is ignored
      mem_done = 1; mem_rdata = 16'hFFFF;
      #1;
      chk("idle_done", {i_done, d_done, i_rdata, d_rdata}, 0);
      step(); mem_done = 0; mem_rdata = '0;
      d_req = 1; d_wr = 0; d_addr = 16'h0500;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      d_req = 0;
      mem_done = 1;
      #1;
      chk("issue_done", {i_done, d_done}, 0);
      mem_done = 0;
      serve(0, -1, 16'h0A0A, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("issue_done_then", {o_ddn, o_drd}, {1'b1, 16'h0A0A});

      // ---- requests during WAIT are not latched
      i_req = 1; i_addr = 16'h0060;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      step(); d_req = 1; d_addr = 16'h0700;
      step(); d_req = 0;
      serve(0, -1, 16'h1357, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      i_req = 0;
      quiet = 0;
      for (int t = 0; t < 4; t++) begin
         step(); #1;
         if (mem_rd | mem_wr) quiet++;
      end
      chk("wait_req_ignored", quiet, 0);

      // ---- memory error is sticky, transaction still completes
      i_req = 1; i_addr = 16'h0090;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      serve(1, -1, 16'h1111, 1, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("err_done", {o_idn, o_ird}, {1'b1, 16'h1111});
      i_req = 0;
      step(); step(); #1;
      chk("err_sticky", err, 1);

      // ---- reset mid-WAIT: immediate zero outputs, no done, clean restart
      i_req = 1; i_addr = 16'h00A0;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      step();
      mem_done = 1; mem_rdata = 16'h2222; rst = 0;
      #1;
      chk("rstw_outs", {i_done, d_done, i_rdata, d_rdata, mem_rd, mem_wr, err}, 0);
      chk("rstw_addr", mem_addr, 0);
      step();
      mem_done = 0; mem_rdata = '0; rst = 1;
      wait_cmd(c_rd, c_wr, c_a, c_wd, n);
      chk("rstw_restart", {n[3:0], c_rd, c_a}, {4'd1, 1'b1, 16'h00A0});
      serve(0, -1, 16'h3333, 0, o_idn, o_ird, o_ddn, o_drd, extra);
      chk("rstw_restart_done", {o_idn, o_ird}, {1'b1, 16'h3333});
      i_req = 0;

      // ---- randomized traffic against the arbitration model
      ipend = 0; dpend = 0; streak = 0;
      for (int it = 0; it < 80; it++) begin
         if (!ipend && $urandom_range(0, 1) == 1) begin
            ipend = 1; ia = 16'($urandom);
         end
         if (!dpend && $urandom_range(0, 1) == 1) begin
            dpend = 1; da = 16'($urandom); dw = 16'($urandom); dwr = 1'($urandom_range(0, 1));
         end
         if (!ipend && !dpend) begin
            ipend = 1; ia = 16'($urandom);
         end
         i_req = ipend; i_addr = ia;
         d_req = dpend; d_addr = da; d_wdata = dw; d_wr = dwr;
         i_flush = ($urandom_range(0, 3) == 0);
         fw = ipend && (!dpend || streak >= SMAX);
         if (fw || !ipend) streak = 0;
         else streak++;
         wait_cmd(c_rd, c_wr, c_a, c_wd, n);
         chk("rnd_lat", n, 1);
         chk("rnd_cmd", {c_rd, c_wr}, fw ? 2'b10 : {~dwr, dwr});
         chk("rnd_addr", c_a, fw ? ia : da);
         if (!fw && dwr) chk("rnd_wdata", c_wd, dw);
         lat = $urandom_range(0, 3);
         fat = (fw && $urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
         rdv = 16'($urandom);
         serve(lat, fat, rdv, 0, o_idn, o_ird, o_ddn, o_drd, extra);
         chk("rnd_idone", {o_idn, o_ird}, (fw && fat < 0) ? {1'b1, rdv} : 17'd0);
         chk("rnd_ddone", {o_ddn, o_drd}, fw ? 17'd0 : {1'b1, dwr ? 16'h0 : rdv});
         chk("rnd_extra", extra, 0);
         if (fw) ipend = 0;
         else dpend = 0;
      end
      i_req = 0; d_req = 0;
      step(); #1;
      chk("rnd_err_clear", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
